m_opqueue: RTL and testbench

M_OPQUEUE -- requirements
Module: m_opqueue

---
 rtl/m_opqueue_pkg.sv | 28 ++
 rtl/m_opqueue_ram.sv | 69 ++++++
 rtl/m_opqueue.sv | 143 ++++++++++++++
 tb/tb_m_opqueue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_opqueue_pkg.sv
// -----------------------------------------------------------------------------
// m_opqueue_pkg
// Shared constants for the instruction queue: instruction width, the bit
// positions of the decoded register/function fields, and the check applied
// to the DEPTH parameter.
// -----------------------------------------------------------------------------
package m_opqueue_pkg;

  localparam int INSTR_W = 32;

  // Decoded field positions inside a RISC-V instruction word.
  localparam int TRG_HI     = 11;
  localparam int TRG_LO     = 7;
  localparam int FUNC3_HI   = 14;
  localparam int FUNC3_LO   = 12;
  localparam int SRC1_HI    = 19;
  localparam int SRC1_LO    = 15;
  localparam int SRC2_HI    = 24;
  localparam int SRC2_LO    = 20;
  localparam int FUNC7_5_BIT = 30;

  // Pointers wrap by natural binary overflow, so only these powers of two
  // are supported.
  function automatic bit depth_is_legal(input int depth);
    return (depth == 2) || (depth == 4) || (depth == 8);
  endfunction

endpackage

// File: rtl/m_opqueue_ram.sv
// -----------------------------------------------------------------------------
// m_opqueue_ram
// DEPTH x INSTR_W storage for the instruction queue. One synchronous write
// port, one asynchronous read port. Contents are never reset.
//
// Parameters:
//   DEPTH      number of words
//   HIGHLEVEL  1: behavioural memory array
//              0: one clock-enable flop per bit (SB_DFFE cell shape)
// Ports:
//   clk      clock
//   we_i     write enable (an accepted push)
//   waddr_i  write address (write pointer)
//   wdata_i  write data
//   raddr_i  read address (read pointer)
//   rdata_o  word at raddr_i, combinational
// -----------------------------------------------------------------------------
module m_opqueue_ram
  import m_opqueue_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int HIGHLEVEL = 0
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [INSTR_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [INSTR_W-1:0]         rdata_o
);

  localparam int AW = $clog2(DEPTH);

  if (HIGHLEVEL != 0) begin : g_behav
    logic [INSTR_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset branch on purpose; the pointers and count
    // already make stale words invisible, and resetting an array costs a
    // mux per bit.
    always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
  end else begin : g_prim
    logic [INSTR_W-1:0] words [DEPTH];

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
      logic               wen;
      logic [INSTR_W-1:0] word;

      assign wen = we_i && (waddr_i == AW'(w));

      // Each bit is a D flop with clock enable and no reset.
      for (genvar b = 0; b < INSTR_W; b++) begin : g_bit
        logic bit_q;
        always_ff @(posedge clk) begin
          if (wen) bit_q <= wdata_i[b];
        end
        assign word[b] = bit_q;
      end

      assign words[w] = word;
    end

    assign rdata_o = words[raddr_i];
  end

endmodule

// File: rtl/m_opqueue.sv
// -----------------------------------------------------------------------------
// m_opqueue
// Circular instruction queue between fetch and decode. Holds up to DEPTH
// words, presents the head word with its decoded register/function fields,
// and records a sticky overflow when a push has to be dropped.
//
// Optional feature (macro M_OPQUEUE_BYPASS_EN): when the queue is empty a
// pushed word is presented on valid/INSTR in the same cycle; if it is also
// popped in that cycle it is consumed without being stored.
//
// Parameters: DEPTH (2, 4 or 8), HIGHLEVEL (storage style, see m_opqueue_ram)
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   push, Di             write Di at the tail
//   pop                  consume the head (ignored when empty)
//   flush                discard everything, clear overflow (beats push/pop)
//   valid, INSTR         head present / head word (0 when not valid)
//   TRG SRC1 SRC2 FUNC3 FUNC7_5  slices of INSTR
//   full, count          occupancy status
//   overflow             sticky: a push was dropped
// -----------------------------------------------------------------------------
module m_opqueue
  import m_opqueue_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int HIGHLEVEL = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       Di,
  output logic                     full,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     valid,
  output logic [INSTR_W-1:0]       INSTR,
  output logic [4:0]               TRG,
  output logic [4:0]               SRC1,
  output logic [4:0]               SRC2,
  output logic [2:0]               FUNC3,
  output logic                     FUNC7_5,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (!depth_is_legal(DEPTH)) begin : g_illegal_depth
    $error("m_opqueue: DEPTH must be 2, 4 or 8");
  end

  logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               is_empty, is_full;
  logic               push_acc, pop_acc, bypass_take;
  logic [INSTR_W-1:0] rdata;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // NOTE: every variable written here gets its default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    push_acc    = 1'b0;
    pop_acc     = 1'b0;
    bypass_take = 1'b0;

    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
`ifdef M_OPQUEUE_BYPASS_EN
      // Empty queue, word pushed and popped together: it flows straight
      // through and never touches storage.
      bypass_take = push && pop && is_empty;
`endif
      pop_acc  = pop && !is_empty;
      // A full queue still accepts a push when the head leaves in the same
      // cycle, since that frees the slot being written.
      push_acc = push && !bypass_take && (!is_full || pop_acc);
      if (push && !bypass_take && !push_acc) overflow_d = 1'b1;
      // DEPTH is a power of two, so pointer wrap is plain binary overflow.
      if (push_acc) wp_d = wp_q + PW'(1);
      if (pop_acc)  rp_d = rp_q + PW'(1);
      count_d = count_q + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Reset also blocks the write so a push during reset leaves storage alone.
  m_opqueue_ram #(
    .DEPTH    (DEPTH),
    .HIGHLEVEL(HIGHLEVEL)
  ) u_ram (
    .clk    (clk),
    .we_i   (push_acc && rstn),
    .waddr_i(wp_q),
    .wdata_i(Di),
    .raddr_i(rp_q),
    .rdata_o(rdata)
  );

`ifdef M_OPQUEUE_BYPASS_EN
  assign valid = !is_empty || push;
  assign INSTR = !is_empty ? rdata : (push ? Di : '0);
`else
  assign valid = !is_empty;
  assign INSTR = !is_empty ? rdata : '0;
`endif

  assign TRG      = INSTR[TRG_HI:TRG_LO];
  assign SRC1     = INSTR[SRC1_HI:SRC1_LO];
  assign SRC2     = INSTR[SRC2_HI:SRC2_LO];
  assign FUNC3    = INSTR[FUNC3_HI:FUNC3_LO];
  assign FUNC7_5  = INSTR[FUNC7_5_BIT];
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_m_opqueue.sv
// -----------------------------------------------------------------------------
// tb_m_opqueue
// Three queue instances (DEPTH 2, 4, 8; the DEPTH 4 one uses behavioural
// storage) driven by directed scenarios and by random traffic compared with
// a queue-based model of the occupancy/overflow rules.
// -----------------------------------------------------------------------------
module tb_m_opqueue;

`ifdef M_OPQUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        push_s  [3];
  logic        pop_s   [3];
  logic        flush_s [3];
  logic [31:0] di_s    [3];

  wire  [31:0] instr_w [3];
  wire         valid_w [3];
  wire         full_w  [3];
  wire         ovf_w   [3];
  wire  [4:0]  trg_w   [3];
  wire  [4:0]  src1_w  [3];
  wire  [4:0]  src2_w  [3];
  wire  [2:0]  f3_w    [3];
  wire         f7_w    [3];
  wire  [3:0]  cnt_w   [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue contents and sticky overflow per instance.
  logic [31:0] mq [3][$];
  bit          movf [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = 2 << g;
    wire [$clog2(D):0] c;
    m_opqueue #(.DEPTH(D), .HIGHLEVEL(g == 1 ? 1 : 0)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .push    (push_s[g]),
      .Di      (di_s[g]),
      .full    (full_w[g]),
      .pop     (pop_s[g]),
      .flush   (flush_s[g]),
      .valid   (valid_w[g]),
      .INSTR   (instr_w[g]),
      .TRG     (trg_w[g]),
      .SRC1    (src1_w[g]),
      .SRC2    (src2_w[g]),
      .FUNC3   (f3_w[g]),
      .FUNC7_5 (f7_w[g]),
      .count   (c),
      .overflow(ovf_w[g])
    );
    assign cnt_w[g] = 4'(c);
  end

  function automatic int depth_of(input int k);
    return 2 << k;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      push_s[k] = 1'b0; pop_s[k] = 1'b0; flush_s[k] = 1'b0; di_s[k] = '0;
    end
  endtask

  // Advance one clock edge with the currently driven inputs, update the
  // model from the same inputs, then release the inputs.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rstn || flush_s[k]) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end else begin
        int sz = mq[k].size();
        bit through = BYP && push_s[k] && pop_s[k] && (sz == 0);
        bit take    = pop_s[k] && (sz > 0);
        bit store   = push_s[k] && !through && (sz < depth_of(k) || take);
        if (take)  void'(mq[k].pop_front());
        if (store) mq[k].push_back(di_s[k]);
        if (push_s[k] && !through && !store) movf[k] = 1'b1;
      end
    end
    #1;
    clear_inputs();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (cnt_w[k] !== 4'd0) begin n_fail++; $display("FAIL reset_count[%0d] got %0d want 0", k, cnt_w[k]); end
      n_tests++; if (valid_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", k, valid_w[k]); end
      n_tests++; if (full_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_full[%0d] got %b want 0", k, full_w[k]); end
      n_tests++; if (ovf_w[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf[%0d] got %b want 0", k, ovf_w[k]); end
      n_tests++; if (instr_w[k] !== 32'h0 || trg_w[k] !== 5'd0) begin n_fail++; $display("FAIL reset_instr[%0d] got %h want 0", k, instr_w[k]); end
    end
  endtask

  task automatic test_fill_drain();
    push_s[0] = 1'b1; di_s[0] = 32'h00A00093; cycle();
    push_s[0] = 1'b1; di_s[0] = 32'h002081B3; cycle();
    n_tests++; if (cnt_w[0] !== 4'd2) begin n_fail++; $display("FAIL fd_count got %0d want 2", cnt_w[0]); end
    n_tests++; if (full_w[0] !== 1'b1) begin n_fail++; $display("FAIL fd_full got %b want 1", full_w[0]); end
    n_tests++; if (instr_w[0] !== 32'h00A00093) begin n_fail++; $display("FAIL fd_head1 got %h want 00a00093", instr_w[0]); end
    n_tests++; if (trg_w[0] !== 5'd1 || src1_w[0] !== 5'd0 || f3_w[0] !== 3'd0) begin
      n_fail++; $display("FAIL fd_fields1 got trg=%0d src1=%0d f3=%0d want 1/0/0", trg_w[0], src1_w[0], f3_w[0]);
    end
    pop_s[0] = 1'b1; cycle();
    n_tests++; if (instr_w[0] !== 32'h002081B3) begin n_fail++; $display("FAIL fd_head2 got %h want 002081b3", instr_w[0]); end
    n_tests++; if (trg_w[0] !== 5'd3 || src1_w[0] !== 5'd1 || src2_w[0] !== 5'd2) begin
      n_fail++; $display("FAIL fd_fields2 got trg=%0d src1=%0d src2=%0d want 3/1/2", trg_w[0], src1_w[0], src2_w[0]);
    end
    pop_s[0] = 1'b1; cycle();
    n_tests++; if (valid_w[0] !== 1'b0 || instr_w[0] !== 32'h0) begin
      n_fail++; $display("FAIL fd_empty got valid=%b instr=%h want 0/0", valid_w[0], instr_w[0]);
    end
  endtask

  task automatic test_overflow();
    push_s[0] = 1'b1; di_s[0] = 32'h12345678; cycle();
    push_s[0] = 1'b1; di_s[0] = 32'h9ABCDEF0; cycle();
    push_s[0] = 1'b1; di_s[0] = 32'hDEADBEEF; cycle();
    n_tests++; if (ovf_w[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf_w[0]); end
    n_tests++; if (cnt_w[0] !== 4'd2 || instr_w[0] !== 32'h12345678) begin
      n_fail++; $display("FAIL ovf_keep got count=%0d head=%h want 2/12345678", cnt_w[0], instr_w[0]);
    end
    pop_s[0] = 1'b1; cycle();
    n_tests++; if (instr_w[0] !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL ovf_tail got %h want 9abcdef0", instr_w[0]); end
    flush_s[0] = 1'b1; cycle();
    n_tests++; if (cnt_w[0] !== 4'd0 || ovf_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_flush got count=%0d ovf=%b want 0/0", cnt_w[0], ovf_w[0]);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [$];
    // Move both pointers to 3 so the next four pushes wrap wp.
    for (int i = 0; i < 3; i++) begin push_s[1] = 1'b1; di_s[1] = $urandom; cycle(); end
    for (int i = 0; i < 3; i++) begin pop_s[1] = 1'b1; cycle(); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v = $urandom;
      push_s[1] = 1'b1; di_s[1] = v; exp_q.push_back(v); cycle();
    end
    n_tests++; if (full_w[1] !== 1'b1 || cnt_w[1] !== 4'd4) begin
      n_fail++; $display("FAIL fpp_full got full=%b count=%0d want 1/4", full_w[1], cnt_w[1]);
    end
    push_s[1] = 1'b1; pop_s[1] = 1'b1; di_s[1] = 32'h11111111; cycle();
    void'(exp_q.pop_front());
    exp_q.push_back(32'h11111111);
    n_tests++; if (cnt_w[1] !== 4'd4 || ovf_w[1] !== 1'b0) begin
      n_fail++; $display("FAIL fpp_count got count=%0d ovf=%b want 4/0", cnt_w[1], ovf_w[1]);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (instr_w[1] !== exp_q[i]) begin n_fail++; $display("FAIL fpp_order[%0d] got %h want %h", i, instr_w[1], exp_q[i]); end
      pop_s[1] = 1'b1; cycle();
    end
    n_tests++; if (valid_w[1] !== 1'b0) begin n_fail++; $display("FAIL fpp_drained got valid=%b want 0", valid_w[1]); end
  endtask

  task automatic test_flush_priority();
    push_s[0] = 1'b1; di_s[0] = 32'h00500113; cycle();
    n_tests++; if (cnt_w[0] !== 4'd1) begin n_fail++; $display("FAIL fp_pre got count=%0d want 1", cnt_w[0]); end
    flush_s[0] = 1'b1; push_s[0] = 1'b1; pop_s[0] = 1'b1; di_s[0] = 32'hCAFEF00D; cycle();
    n_tests++; if (cnt_w[0] !== 4'd0 || valid_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL fp_flush got count=%0d valid=%b want 0/0", cnt_w[0], valid_w[0]);
    end
  endtask

  task automatic test_empty_push_pop();
    push_s[0] = 1'b1; pop_s[0] = 1'b1; di_s[0] = 32'h40000033;
    #1;
`ifdef M_OPQUEUE_BYPASS_EN
    n_tests++; if (valid_w[0] !== 1'b1 || instr_w[0] !== 32'h40000033) begin
      n_fail++; $display("FAIL epp_bypass got valid=%b instr=%h want 1/40000033", valid_w[0], instr_w[0]);
    end
    cycle();
    n_tests++; if (cnt_w[0] !== 4'd0) begin n_fail++; $display("FAIL epp_consumed got count=%0d want 0", cnt_w[0]); end
`else
    n_tests++; if (valid_w[0] !== 1'b0) begin n_fail++; $display("FAIL epp_nobypass got valid=%b want 0", valid_w[0]); end
    cycle();
    n_tests++; if (cnt_w[0] !== 4'd1 || f7_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL epp_stored got count=%0d f7_5=%b want 1/1", cnt_w[0], f7_w[0]);
    end
`endif
    flush_s[0] = 1'b1; cycle();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 9; i++) begin push_s[2] = 1'b1; di_s[2] = $urandom; cycle(); end
    for (int i = 0; i < 3; i++) begin pop_s[2] = 1'b1; cycle(); end
    n_tests++; if (cnt_w[2] !== 4'd5 || ovf_w[2] !== 1'b1) begin
      n_fail++; $display("FAIL mr_pre got count=%0d ovf=%b want 5/1", cnt_w[2], ovf_w[2]);
    end
    rstn = 1'b0; push_s[2] = 1'b1; di_s[2] = 32'hFFFFFFFF; cycle();
    rstn = 1'b1;
    n_tests++; if (cnt_w[2] !== 4'd0 || ovf_w[2] !== 1'b0 || valid_w[2] !== 1'b0) begin
      n_fail++; $display("FAIL mr_post got count=%0d ovf=%b valid=%b want 0/0/0", cnt_w[2], ovf_w[2], valid_w[2]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 600; it++) begin
      rstn = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < 3; k++) begin
        push_s[k]  = ($urandom_range(0, 9) < 6);
        pop_s[k]   = ($urandom_range(0, 9) < 5);
        flush_s[k] = ($urandom_range(0, 49) == 0);
        di_s[k]    = $urandom;
      end
      #1;
      // Head as seen before the edge, including a same-cycle bypassed word.
      for (int k = 0; k < 3; k++) begin
        logic        ev = (mq[k].size() != 0) || (BYP && push_s[k]);
        logic [31:0] ei = (mq[k].size() != 0) ? mq[k][0] : ((BYP && push_s[k]) ? di_s[k] : 32'h0);
        n_tests++; if (valid_w[k] !== ev || instr_w[k] !== ei) begin
          n_fail++; $display("FAIL rnd_comb[%0d] it=%0d got valid=%b instr=%h want %b/%h", k, it, valid_w[k], instr_w[k], ev, ei);
        end
      end
      cycle();
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
        int          sz = mq[k].size();
        logic [31:0] ei = (sz != 0) ? mq[k][0] : 32'h0;
        n_tests++; if (cnt_w[k] !== 4'(sz) || full_w[k] !== (sz == depth_of(k)) || valid_w[k] !== (sz != 0)) begin
          n_fail++; $display("FAIL rnd_occ[%0d] it=%0d got count=%0d full=%b valid=%b want count=%0d", k, it, cnt_w[k], full_w[k], valid_w[k], sz);
        end
        n_tests++; if (ovf_w[k] !== movf[k]) begin
          n_fail++; $display("FAIL rnd_ovf[%0d] it=%0d got %b want %b", k, it, ovf_w[k], movf[k]);
        end
        n_tests++; if (instr_w[k] !== ei || trg_w[k] !== 5'((ei >> 7) & 32'h1F) || src1_w[k] !== 5'((ei >> 15) & 32'h1F)
                       || src2_w[k] !== 5'((ei >> 20) & 32'h1F) || f3_w[k] !== 3'((ei >> 12) & 32'h7) || f7_w[k] !== ((ei >> 30) & 32'h1) != 0) begin
          n_fail++; $display("FAIL rnd_head[%0d] it=%0d got %h trg=%0d s1=%0d s2=%0d f3=%0d f7=%b want %h", k, it,
                             instr_w[k], trg_w[k], src1_w[k], src2_w[k], f3_w[k], f7_w[k], ei);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_flush_priority();
    test_empty_push_pop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
